audio_mix_seq: RTL and testbench

- Parametrised, time-multiplexed stereo audio mixer; successor to the fixed TIA-LUT + POKEY + YM sum at the console top level.
- Mixes NUM_CH unsigned sources, one channel per clock, on each sample strobe.
- Applies per-channel gain, mute and L/R routing, then saturates instead of wrapping.
- Sits between the sound sources (TIA LUT, POKEY, YM) and AUDIO_L/AUDIO_R.

---
 rtl/audio_mix_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_audio_mix_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_seq.sv
`default_nettype none
// ============================================================================
// Module      : audio_mix_seq
// Description : Time-multiplexed stereo mixer. On each sample_ce strobe the
//               channel inputs are snapshotted and summed one channel per
//               clock into wide left/right accumulators (gain, mute, L/R
//               routing applied per channel). The sums saturate to OUT_W.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_sys     in   1              system clock
//   reset_n     in   1              asynchronous active-low reset
//   sample_ce   in   1              one-cycle strobe starting a mix pass
//   ch_in       in   NUM_CH*IN_W    channel samples, ch k at [k*IN_W +: IN_W]
//   ch_gain     in   NUM_CH*GAIN_W  per-channel gain, unity = 2^(GAIN_W-1)
//   ch_mute     in   NUM_CH         1 = channel contributes 0
//   ch_route_l  in   NUM_CH         1 = channel feeds left sum
//   ch_route_r  in   NUM_CH         1 = channel feeds right sum
//   out_l/out_r out  OUT_W          mixed samples, held between passes
//   out_valid   out  1              one-cycle pulse when out_l/out_r update
//   busy        out  1              high while channels are being summed
//   overrun     out  1              sticky: sample_ce seen while not idle
// Optional (define AUDIO_MIX_PEAK_EN):
//   peak_clr    in   1              synchronous clear of peak/clip
//   peak_l/r    out  OUT_W          running maximum of out_l/out_r
//   clip        out  1              sticky: a pass saturated
// ============================================================================
module audio_mix_seq #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int GAIN_W = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     sample_ce,
    input  logic [NUM_CH*IN_W-1:0]   ch_in,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic [NUM_CH-1:0]        ch_mute,
    input  logic [NUM_CH-1:0]        ch_route_l,
    input  logic [NUM_CH-1:0]        ch_route_r,
    output logic [OUT_W-1:0]         out_l,
    output logic [OUT_W-1:0]         out_r,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
`ifdef AUDIO_MIX_PEAK_EN
    ,
    input  logic                     peak_clr,
    output logic [OUT_W-1:0]         peak_l,
    output logic [OUT_W-1:0]         peak_r,
    output logic                     clip
`endif
);

    localparam int C_IDX_W  = $clog2(NUM_CH);
    localparam int C_PROD_W = IN_W + GAIN_W;
    localparam int C_ACC_W  = IN_W + GAIN_W + $clog2(NUM_CH);
    localparam int C_CMP_W  = (C_ACC_W > OUT_W) ? C_ACC_W : OUT_W;
    localparam logic [C_IDX_W-1:0] C_LAST    = C_IDX_W'(NUM_CH - 1);
    localparam logic [C_CMP_W-1:0] C_OUT_MAX = C_CMP_W'({OUT_W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Snapshot of the channel controls taken at the start of each pass
    logic [NUM_CH*IN_W-1:0]   r_snap_in;
    logic [NUM_CH*GAIN_W-1:0] r_snap_gain;
    logic [NUM_CH-1:0]        r_snap_mute;
    logic [NUM_CH-1:0]        r_snap_rl;
    logic [NUM_CH-1:0]        r_snap_rr;

    logic [C_IDX_W-1:0] r_idx;
    logic [C_ACC_W-1:0] r_acc_l;
    logic [C_ACC_W-1:0] r_acc_r;
    logic [OUT_W-1:0]   r_out_l;
    logic [OUT_W-1:0]   r_out_r;
    logic               r_overrun;

    logic [IN_W-1:0]     w_sample;
    logic [GAIN_W-1:0]   w_gain;
    logic                w_mute;
    logic                w_rl;
    logic                w_rr;
    logic [C_PROD_W-1:0] w_prod;
    logic [C_ACC_W-1:0]  w_term;
    logic [C_ACC_W-1:0]  w_acc_l_next;
    logic [C_ACC_W-1:0]  w_acc_r_next;
    logic [C_CMP_W-1:0]  w_l_ext;
    logic [C_CMP_W-1:0]  w_r_ext;
    logic                w_l_over;
    logic                w_r_over;
    logic [OUT_W-1:0]    w_out_l_sat;
    logic [OUT_W-1:0]    w_out_r_sat;
    logic                w_last;

    // ------------------------------------------------------------------
    // Channel select and per-channel term
    // ------------------------------------------------------------------
    always_comb begin
        w_sample = '0;
        w_gain   = '0;
        w_mute   = 1'b0;
        w_rl     = 1'b0;
        w_rr     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_idx == C_IDX_W'(k)) begin
                w_sample = r_snap_in[k*IN_W +: IN_W];
                w_gain   = r_snap_gain[k*GAIN_W +: GAIN_W];
                w_mute   = r_snap_mute[k];
                w_rl     = r_snap_rl[k];
                w_rr     = r_snap_rr[k];
            end
        end
    end

    always_comb begin
        // Full-width product first so the shift cannot drop high bits
        w_prod       = C_PROD_W'(w_sample) * C_PROD_W'(w_gain);
        w_term       = w_mute ? '0 : C_ACC_W'(w_prod >> (GAIN_W - 1));
        w_acc_l_next = r_acc_l + (w_rl ? w_term : '0);
        w_acc_r_next = r_acc_r + (w_rr ? w_term : '0);
        w_last       = (r_idx == C_LAST);

        // Saturate the completed sums; no rescaling when OUT_W > IN_W
        w_l_ext     = C_CMP_W'(w_acc_l_next);
        w_r_ext     = C_CMP_W'(w_acc_r_next);
        w_l_over    = (w_l_ext > C_OUT_MAX);
        w_r_over    = (w_r_ext > C_OUT_MAX);
        w_out_l_sat = w_l_over ? {OUT_W{1'b1}} : w_l_ext[OUT_W-1:0];
        w_out_r_sat = w_r_over ? {OUT_W{1'b1}} : w_r_ext[OUT_W-1:0];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_ce) begin
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                out_valid    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_in   <= '0;
            r_snap_gain <= '0;
            r_snap_mute <= '0;
            r_snap_rl   <= '0;
            r_snap_rr   <= '0;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_out_l     <= '0;
            r_out_r     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sample_ce) begin
                        r_snap_in   <= ch_in;
                        r_snap_gain <= ch_gain;
                        r_snap_mute <= ch_mute;
                        r_snap_rl   <= ch_route_l;
                        r_snap_rr   <= ch_route_r;
                        r_idx       <= '0;
                        r_acc_l     <= '0;
                        r_acc_r     <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc_l <= w_acc_l_next;
                    r_acc_r <= w_acc_r_next;
                    if (w_last) begin
                        // Saturated result is loaded on entry to FINISH so it
                        // is already on out_l/out_r while out_valid is high.
                        r_out_l <= w_out_l_sat;
                        r_out_r <= w_out_r_sat;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + C_IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Any strobe outside IDLE (including the FINISH cycle) is an overrun
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (sample_ce && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign out_l   = r_out_l;
    assign out_r   = r_out_r;
    assign overrun = r_overrun;

`ifdef AUDIO_MIX_PEAK_EN
    // ------------------------------------------------------------------
    // Peak hold and clip detection
    // ------------------------------------------------------------------
    logic             r_sat_l;
    logic             r_sat_r;
    logic [OUT_W-1:0] r_peak_l;
    logic [OUT_W-1:0] r_peak_r;
    logic             r_clip;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_l  <= 1'b0;
            r_sat_r  <= 1'b0;
            r_peak_l <= '0;
            r_peak_r <= '0;
            r_clip   <= 1'b0;
        end else begin
            if ((r_state == S_ACCUM) && w_last) begin
                r_sat_l <= w_l_over;
                r_sat_r <= w_r_over;
            end
            // Peaks fold in the new sample at the end of the out_valid cycle;
            // a coincident clear restarts them from that sample, not from 0.
            if (r_state == S_FINISH) begin
                if (peak_clr) begin
                    r_peak_l <= r_out_l;
                    r_peak_r <= r_out_r;
                    r_clip   <= r_sat_l | r_sat_r;
                end else begin
                    if (r_out_l > r_peak_l) begin
                        r_peak_l <= r_out_l;
                    end
                    if (r_out_r > r_peak_r) begin
                        r_peak_r <= r_out_r;
                    end
                    r_clip <= r_clip | r_sat_l | r_sat_r;
                end
            end else if (peak_clr) begin
                r_peak_l <= '0;
                r_peak_r <= '0;
                r_clip   <= 1'b0;
            end
        end
    end

    assign peak_l = r_peak_l;
    assign peak_r = r_peak_r;
    assign clip   = r_clip;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_mix_seq
// Description : Scoreboard bench for audio_mix_seq (NUM_CH=4, GAIN_W=4).
//               Expected results are queued when a pass is started; a monitor
//               pops and compares them on every out_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_mix_seq;

    localparam int NUM_CH = 4;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int GAIN_W = 4;

    logic                     clk_sys = 1'b0;
    logic                     reset_n;
    logic                     sample_ce;
    logic [NUM_CH*IN_W-1:0]   ch_in;
    logic [NUM_CH*GAIN_W-1:0] ch_gain;
    logic [NUM_CH-1:0]        ch_mute;
    logic [NUM_CH-1:0]        ch_route_l;
    logic [NUM_CH-1:0]        ch_route_r;
    logic [OUT_W-1:0]         out_l;
    logic [OUT_W-1:0]         out_r;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;
`ifdef AUDIO_MIX_PEAK_EN
    logic                     peak_clr;
    logic [OUT_W-1:0]         peak_l;
    logic [OUT_W-1:0]         peak_r;
    logic                     clip;
`endif

    audio_mix_seq #(
        .NUM_CH (NUM_CH),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .GAIN_W (GAIN_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .sample_ce  (sample_ce),
        .ch_in      (ch_in),
        .ch_gain    (ch_gain),
        .ch_mute    (ch_mute),
        .ch_route_l (ch_route_l),
        .ch_route_r (ch_route_r),
        .out_l      (out_l),
        .out_r      (out_r),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
`ifdef AUDIO_MIX_PEAK_EN
        ,
        .peak_clr   (peak_clr),
        .peak_l     (peak_l),
        .peak_r     (peak_r),
        .clip       (clip)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [OUT_W-1:0] l;
        logic [OUT_W-1:0] r;
        int               cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   valid_count = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every out_valid must match the oldest queued expectation
    always @(negedge clk_sys) begin
        if (reset_n && out_valid) begin
            valid_count++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_l", 32'(out_l), 32'(e.l));
                check("out_r", 32'(out_r), 32'(e.r));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic set_ch(input int k, input logic [IN_W-1:0] s, input logic [GAIN_W-1:0] g,
                          input logic m, input logic rl, input logic rr);
        ch_in[k*IN_W +: IN_W]       = s;
        ch_gain[k*GAIN_W +: GAIN_W] = g;
        ch_mute[k]                  = m;
        ch_route_l[k]               = rl;
        ch_route_r[k]               = rr;
    endtask

    // Pulse sample_ce for one cycle; returns at the negedge of cycle T+1
    task automatic start_pass(input logic [OUT_W-1:0] el, input logic [OUT_W-1:0] er,
                              input bit expect_out);
        exp_t e;
        @(negedge clk_sys);
        sample_ce = 1'b1;
        if (expect_out) begin
            e.l   = el;
            e.r   = er;
            e.cyc = cyc + NUM_CH + 1;
            sbq.push_back(e);
        end
        @(negedge clk_sys);
        sample_ce = 1'b0;
    endtask

    // Bounded wait for the next out_valid; returns just after its negedge
    task automatic wait_done(input string name);
        int start;
        bit seen;
        start = valid_count;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            #1;
            if (valid_count != start) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid expected one within 20 cycles", name);
        end
    endtask

    task automatic unity_cfg(input logic [IN_W-1:0] ch0);
        set_ch(0, ch0,      4'd8, 1'b0, 1'b1, 1'b0);
        set_ch(1, 16'h2000, 4'd8, 1'b0, 1'b0, 1'b1);
        set_ch(2, 16'h0100, 4'd8, 1'b0, 1'b1, 1'b1);
        set_ch(3, 16'h0000, 4'd8, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        reset_n   = 1'b0;
        sample_ce = 1'b0;
        ch_in     = '0;
        ch_gain   = '0;
        ch_mute   = '0;
        ch_route_l = '0;
        ch_route_r = '0;
`ifdef AUDIO_MIX_PEAK_EN
        peak_clr  = 1'b0;
`endif
        repeat (3) @(negedge clk_sys);
        check("rst_out_l", 32'(out_l), 32'h0);
        check("rst_out_r", 32'(out_r), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;

        // Idle: no strobe, no output
        repeat (100) @(negedge clk_sys);
        check("idle_no_valid", 32'(valid_count), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // Unity mix with busy window T+1..T+4
        unity_cfg(16'h1000);
        start_pass(16'h1100, 16'h2100, 1'b1);
        check("busy_t1", 32'(busy), 32'h1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk_sys);
            check("busy_t2_t4", 32'(busy), 32'h1);
        end
        @(negedge clk_sys);
        check("busy_t5", 32'(busy), 32'h0);
        wait_done("unity");
        check("unity_hold_l", 32'(out_l), 32'h1100);

        // Saturation: 3 x (0xC000*15>>3)=0x43800 clamps, ch3 muted
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'hC000, 4'd15, (k == 3), 1'b1, 1'b1);
        start_pass(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("saturate");

        // All channels muted
        ch_mute = '1;
        start_pass(16'h0000, 16'h0000, 1'b1);
        wait_done("all_muted");

        // Snapshot and overrun: ch0 changed and strobe repeated mid-pass
        unity_cfg(16'h1000);
        check("overrun_before", 32'(overrun), 32'h0);
        start_pass(16'h1100, 16'h2100, 1'b1);
        @(negedge clk_sys);
        ch_in[0 +: IN_W] = 16'h3000;
        sample_ce = 1'b1;
        @(negedge clk_sys);
        sample_ce = 1'b0;
        #1;
        check("overrun_set", 32'(overrun), 32'h1);
        wait_done("snapshot_old");
        // Back-to-back pass from the cycle after out_valid uses new ch0
        start_pass(16'h3100, 16'h2100, 1'b1);
        wait_done("snapshot_new");
        check("overrun_sticky", 32'(overrun), 32'h1);

        // Reset mid-pass aborts with no out_valid
        vc = valid_count;
        start_pass(16'h0000, 16'h0000, 1'b0);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_out_l", 32'(out_l), 32'h0);
        check("midrst_out_r", 32'(out_r), 32'h0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        check("midrst_no_valid", 32'(valid_count), 32'(vc));
        check("midrst_overrun_clr", 32'(overrun), 32'h0);

`ifdef AUDIO_MIX_PEAK_EN
        // Peak hold: 0x0800, 0x0400, then saturated 0xFFFF
        for (int k = 1; k < NUM_CH; k++) set_ch(k, 16'h0000, 4'd8, 1'b0, 1'b0, 1'b0);
        set_ch(0, 16'h0800, 4'd8, 1'b0, 1'b1, 1'b0);
        start_pass(16'h0800, 16'h0000, 1'b1);
        wait_done("peak1");
        @(negedge clk_sys);
        check("peak_l_1", 32'(peak_l), 32'h0800);
        check("clip_1", 32'(clip), 32'h0);
        set_ch(0, 16'h0400, 4'd8, 1'b0, 1'b1, 1'b0);
        start_pass(16'h0400, 16'h0000, 1'b1);
        wait_done("peak2");
        @(negedge clk_sys);
        check("peak_l_2", 32'(peak_l), 32'h0800);
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'hC000, 4'd15, 1'b0, 1'b1, 1'b1);
        start_pass(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("peak3");
        @(negedge clk_sys);
        check("peak_l_3", 32'(peak_l), 32'hFFFF);
        check("clip_3", 32'(clip), 32'h1);
        peak_clr = 1'b1;
        @(negedge clk_sys);
        peak_clr = 1'b0;
        check("peak_l_clr", 32'(peak_l), 32'h0);
        check("clip_clr", 32'(clip), 32'h0);
`endif

        repeat (5) @(negedge clk_sys);
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
